// File: rtl/uart_cmd_receiver_if.sv
// Output bundle of the robot drive-command UART receiver.
// master: the receiver driving decoded results; slave: the motor controller consuming them.
interface uart_cmd_receiver_if;
    logic [2:0] cmd;
    logic [2:0] multiplier;
    logic       cmd_valid;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_err;
    logic       parse_err;
    logic       timeout;

    modport master (
        output cmd, multiplier, cmd_valid, rx_byte, rx_byte_valid,
               frame_err, parse_err, timeout
    );

    modport slave (
        input  cmd, multiplier, cmd_valid, rx_byte, rx_byte_valid,
               frame_err, parse_err, timeout
    );
endinterface

// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver: base-side receiver of the robot drive-command link.
// Deserialises 8N1 frames, parses <cmd><mult><LF> messages and presents the
// decoded drive command and multiplier with a one-cycle cmd_valid pulse.
// Optional feature macro: CMD_TIMEOUT_EN adds a failsafe watchdog that forces
// STOP / x1 when no valid message arrives for TIMEOUT_CYCLES clocks.
module uart_cmd_receiver #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 25_000_000
`endif
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                uart_in,
    uart_cmd_receiver_if.master cmd_bus
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int HALF_BIT   = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [7:0]    LF        = 8'h0A;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_CMD, P_MULT, P_END} p_state_t;

    // Returns {legal, code} for a command letter.
    function automatic logic [3:0] decode_cmd(input logic [7:0] b);
        case (b)
            8'h53:   decode_cmd = {1'b1, 3'd0};   // 'S' stop
            8'h46:   decode_cmd = {1'b1, 3'd1};   // 'F' forward
            8'h42:   decode_cmd = {1'b1, 3'd2};   // 'B' back
            8'h4C:   decode_cmd = {1'b1, 3'd3};   // 'L' left
            8'h52:   decode_cmd = {1'b1, 3'd4};   // 'R' right
            default: decode_cmd = {1'b0, 3'd0};
        endcase
    endfunction

    // Returns {legal, value} for a multiplier digit '1'..'7'.
    function automatic logic [3:0] decode_mult(input logic [7:0] b);
        if ((b >= 8'h31) && (b <= 8'h37)) begin
            decode_mult = {1'b1, b[2:0]};
        end else begin
            decode_mult = {1'b0, 3'd0};
        end
    endfunction

    logic [1:0]    sync_r;
    logic          line_s;
    rx_state_t     rx_state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    rx_byte_r;
    logic          rx_byte_valid_r;
    logic          frame_err_r;

    p_state_t      p_state_r;
    logic [2:0]    pend_cmd_r;
    logic [2:0]    pend_mult_r;
    logic [2:0]    cmd_r;
    logic [2:0]    mult_r;
    logic          cmd_valid_r;
    logic          parse_err_r;
    logic [3:0]    cmd_dec_s;
    logic [3:0]    mult_dec_s;

    // Bring the asynchronous line into clk_50; idles high so reset does not fake a start bit.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], uart_in};
        end
    end

    assign line_s = sync_r[1];

    // 8N1 deserialiser: half-bit start qualification, then centre-of-bit sampling.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            rx_state_r      <= RX_IDLE;
            cnt_r           <= '0;
            idx_r           <= 3'd0;
            shift_r         <= 8'h00;
            rx_byte_r       <= 8'h00;
            rx_byte_valid_r <= 1'b0;
            frame_err_r     <= 1'b0;
        end else begin
            rx_byte_valid_r <= 1'b0;
            frame_err_r     <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r <= '0;
                    if (!line_s) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r      <= '0;
                        idx_r      <= 3'd0;
                        // A line that is high again at mid-start was only a glitch.
                        rx_state_r <= line_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {line_s, shift_r[7:1]};
                        if (idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r      <= '0;
                        // Back to IDLE right away so a back-to-back start edge is caught.
                        rx_state_r <= RX_IDLE;
                        if (line_s) begin
                            rx_byte_r       <= shift_r;
                            rx_byte_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    cnt_r      <= '0;
                end
            endcase
        end
    end

    // Decode the current byte for both parser states.
    always_comb begin
        cmd_dec_s  = decode_cmd(rx_byte_r);
        mult_dec_s = decode_mult(rx_byte_r);
    end

`ifdef CMD_TIMEOUT_EN
    localparam logic [24:0] WD_LAST = 25'(TIMEOUT_CYCLES - 1);

    logic [24:0] wd_r;
    logic        timeout_r;
    logic        load_s;

    // A completed message is the only thing that feeds the watchdog.
    always_comb begin
        load_s = rx_byte_valid_r && (p_state_r == P_END) && (rx_byte_r == LF);
    end
`endif

    // Message parser; a partial message only touches the pending registers, never cmd/multiplier.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            p_state_r   <= P_CMD;
            pend_cmd_r  <= 3'd0;
            pend_mult_r <= 3'd1;
            cmd_r       <= 3'd0;
            mult_r      <= 3'd1;
            cmd_valid_r <= 1'b0;
            parse_err_r <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            wd_r        <= 25'd0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            cmd_valid_r <= 1'b0;
            parse_err_r <= 1'b0;
            if (frame_err_r) begin
                p_state_r <= P_CMD;
            end else if (rx_byte_valid_r) begin
                case (p_state_r)
                    P_CMD: begin
                        if (cmd_dec_s[3]) begin
                            pend_cmd_r <= cmd_dec_s[2:0];
                            p_state_r  <= P_MULT;
                        end else if (rx_byte_r != LF) begin
                            parse_err_r <= 1'b1;
                        end
                    end
                    P_MULT: begin
                        if (mult_dec_s[3]) begin
                            pend_mult_r <= mult_dec_s[2:0];
                            p_state_r   <= P_END;
                        end else begin
                            parse_err_r <= 1'b1;
                            p_state_r   <= P_CMD;
                        end
                    end
                    P_END: begin
                        p_state_r <= P_CMD;
                        if (rx_byte_r == LF) begin
                            cmd_r       <= pend_cmd_r;
                            mult_r      <= pend_mult_r;
                            cmd_valid_r <= 1'b1;
                        end else begin
                            parse_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        p_state_r <= P_CMD;
                    end
                endcase
            end
`ifdef CMD_TIMEOUT_EN
            // Watchdog saturates at its last count so the failsafe fires only once.
            if (load_s) begin
                wd_r      <= 25'd0;
                timeout_r <= 1'b0;
            end else if (wd_r == WD_LAST) begin
                if (!timeout_r) begin
                    cmd_r       <= 3'd0;
                    mult_r      <= 3'd1;
                    cmd_valid_r <= 1'b1;
                    timeout_r   <= 1'b1;
                end
            end else begin
                wd_r <= wd_r + 25'd1;
            end
`endif
        end
    end

    assign cmd_bus.cmd           = cmd_r;
    assign cmd_bus.multiplier    = mult_r;
    assign cmd_bus.cmd_valid     = cmd_valid_r;
    assign cmd_bus.rx_byte       = rx_byte_r;
    assign cmd_bus.rx_byte_valid = rx_byte_valid_r;
    assign cmd_bus.frame_err     = frame_err_r;
    assign cmd_bus.parse_err     = parse_err_r;
`ifdef CMD_TIMEOUT_EN
    assign cmd_bus.timeout       = timeout_r;
`else
    assign cmd_bus.timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed bench for uart_cmd_receiver with a scoreboard of expected bytes and messages.
// The line runs faster than 115200 baud to keep the run short; bit timing derives from BAUD.
module tb_uart_cmd_receiver;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 500_000;
    localparam int BIT    = CLK_HZ / BAUD;
`ifdef CMD_TIMEOUT_EN
    localparam int TO_CYCLES = 1000;
`endif

    typedef struct packed {
        logic [2:0] cmd;
        logic [2:0] mult;
        logic       to;
    } msg_t;

    logic clk_50 = 1'b0;
    logic reset;
    logic uart_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cv_cyc = 0;
    int rx_valid_cnt = 0;
    int frame_err_cnt = 0;
    int parse_err_cnt = 0;

    msg_t       msg_q[$];
    logic [7:0] byte_q[$];

    uart_cmd_receiver_if bus();

    uart_cmd_receiver #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD)
`ifdef CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO_CYCLES)
`endif
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .uart_in(uart_in),
        .cmd_bus(bus)
    );

    always #10 clk_50 = ~clk_50;

    // Free-running cycle count for interval measurements.
    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT pulses a result.
    always @(negedge clk_50) begin : mon
        logic [7:0] eb;
        msg_t       em;
        if (bus.rx_byte_valid === 1'b1) begin
            rx_valid_cnt++;
            if (byte_q.size() == 0) begin
                chk("rx_byte_valid spurious", 32'(bus.rx_byte_valid), 32'd0);
            end else begin
                eb = byte_q.pop_front();
                chk("rx_byte", 32'(bus.rx_byte), 32'(eb));
            end
        end
        if (bus.cmd_valid === 1'b1) begin
            last_cv_cyc = cyc;
            if (msg_q.size() == 0) begin
                chk("cmd_valid spurious", 32'(bus.cmd_valid), 32'd0);
            end else begin
                em = msg_q.pop_front();
                chk("cmd", 32'(bus.cmd), 32'(em.cmd));
                chk("multiplier", 32'(bus.multiplier), 32'(em.mult));
                chk("timeout at cmd_valid", 32'(bus.timeout), 32'(em.to));
            end
        end
        if (bus.frame_err === 1'b1) frame_err_cnt++;
        if (bus.parse_err === 1'b1) parse_err_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_in = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            wait_cycles(BIT);
        end
        uart_in = stop_bit;
        wait_cycles(BIT);
        uart_in = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        byte_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic expect_msg(input logic [2:0] c, input logic [2:0] m, input logic t);
        msg_t e;
        e.cmd  = c;
        e.mult = m;
        e.to   = t;
        msg_q.push_back(e);
    endtask

    task automatic send_msg(input logic [7:0] c, input logic [7:0] m,
                            input logic [2:0] ec, input logic [2:0] em, input logic et);
        expect_msg(ec, em, et);
        send_good(c);
        send_good(m);
        send_good(8'h0A);
    endtask

    // Bounded wait for the scoreboard to empty; leftovers count as a failure.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((msg_q.size() != 0 || byte_q.size() != 0) && n < budget) begin
            @(negedge clk_50);
            n++;
        end
        chk({tag, " drained"}, 32'(msg_q.size() + byte_q.size()), 32'd0);
        msg_q.delete();
        byte_q.delete();
    endtask

    initial begin : stim
        int fe0;
        int pe0;
        int rv0;
        int t0;
        reset   = 1'b1;
        uart_in = 1'b1;
        wait_cycles(5);
        chk("reset cmd", 32'(bus.cmd), 32'd0);
        chk("reset multiplier", 32'(bus.multiplier), 32'd1);
        chk("reset rx_byte", 32'(bus.rx_byte), 32'h00);
        chk("reset cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("reset rx_byte_valid", 32'(bus.rx_byte_valid), 32'd0);
        chk("reset frame_err", 32'(bus.frame_err), 32'd0);
        chk("reset parse_err", 32'(bus.parse_err), 32'd0);
        chk("reset timeout", 32'(bus.timeout), 32'd0);

`ifdef CMD_TIMEOUT_EN
        // Failsafe fires on its own after reset when nothing arrives.
        expect_msg(3'd0, 3'd1, 1'b1);
        reset = 1'b0;
        drain("initial failsafe", TO_CYCLES + 200);
        chk("timeout after initial failsafe", 32'(bus.timeout), 32'd1);

        send_msg(8'h46, 8'h32, 3'd1, 3'd2, 1'b0);
        drain("F2", 4 * BIT);
        chk("timeout cleared by F2", 32'(bus.timeout), 32'd0);
        t0 = last_cv_cyc;

        expect_msg(3'd0, 3'd1, 1'b1);
        drain("failsafe after F2", TO_CYCLES + 200);
        chk("failsafe interval", 32'(last_cv_cyc - t0), 32'(TO_CYCLES));
        chk("timeout level", 32'(bus.timeout), 32'd1);

        // Saturated watchdog: a long idle stretch must not repeat the pulse.
        wait_cycles(2 * TO_CYCLES);
        chk("timeout held", 32'(bus.timeout), 32'd1);
        chk("cmd held at stop", 32'(bus.cmd), 32'd0);

        send_msg(8'h42, 8'h31, 3'd2, 3'd1, 1'b0);
        drain("B1", 4 * BIT);
        chk("timeout cleared by B1", 32'(bus.timeout), 32'd0);
        chk("cmd after B1", 32'(bus.cmd), 32'd2);
`else
        reset = 1'b0;
        wait_cycles(20);

        // Test 1: 'F','3',LF.
        send_msg(8'h46, 8'h33, 3'd1, 3'd3, 1'b0);
        drain("F3", 4 * BIT);
        chk("F3 rx_byte_valid count", 32'(rx_valid_cnt), 32'd3);
        chk("F3 frame_err count", 32'(frame_err_cnt), 32'd0);
        chk("F3 parse_err count", 32'(parse_err_cnt), 32'd0);

        // Test 2: 'L' with a low stop bit, then 'R','5',LF.
        send_byte(8'h4C, 1'b0);
        wait_cycles(2 * BIT);
        chk("bad stop frame_err count", 32'(frame_err_cnt), 32'd1);
        chk("bad stop no byte", 32'(rx_valid_cnt), 32'd3);
        send_msg(8'h52, 8'h35, 3'd4, 3'd5, 1'b0);
        drain("R5", 4 * BIT);
        chk("R5 frame_err count", 32'(frame_err_cnt), 32'd1);
        chk("R5 parse_err count", 32'(parse_err_cnt), 32'd0);

        // Test 3: 'F','9',LF: error on the digit, LF then ignored, outputs hold.
        send_good(8'h46);
        send_good(8'h39);
        send_good(8'h0A);
        drain("F9", 4 * BIT);
        chk("F9 parse_err count", 32'(parse_err_cnt), 32'd1);
        chk("F9 cmd held", 32'(bus.cmd), 32'd4);
        chk("F9 multiplier held", 32'(bus.multiplier), 32'd5);

        // Test 4: 200 ns low glitch on the idle line.
        fe0 = frame_err_cnt;
        rv0 = rx_valid_cnt;
        uart_in = 1'b0;
        wait_cycles(10);
        uart_in = 1'b1;
        wait_cycles(12 * BIT);
        chk("glitch rx_byte_valid", 32'(rx_valid_cnt - rv0), 32'd0);
        chk("glitch frame_err", 32'(frame_err_cnt - fe0), 32'd0);

        // Test 5: parser left in P_MULT, reset in the middle of a data bit of 'B'.
        send_good(8'h46);
        drain("F before reset", 2 * BIT);
        uart_in = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 3; i++) begin
            uart_in = (i == 1);   // 'B' = 42h, bits 0..2 = 0,1,0
            wait_cycles(BIT);
        end
        uart_in = 1'b0;
        wait_cycles(BIT / 2);
        reset = 1'b1;
        wait_cycles(3);
        chk("midframe reset cmd", 32'(bus.cmd), 32'd0);
        chk("midframe reset multiplier", 32'(bus.multiplier), 32'd1);
        chk("midframe reset rx_byte", 32'(bus.rx_byte), 32'h00);
        uart_in = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2 * BIT);
        pe0 = parse_err_cnt;
        fe0 = frame_err_cnt;
        send_msg(8'h53, 8'h31, 3'd0, 3'd1, 1'b0);
        drain("S1 after reset", 4 * BIT);
        chk("S1 parse_err", 32'(parse_err_cnt - pe0), 32'd0);
        chk("S1 frame_err", 32'(frame_err_cnt - fe0), 32'd0);
        chk("timeout tied low", 32'(bus.timeout), 32'd0);
`endif

        wait_cycles(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
